// File: rtl/mib_pattern_pkg.sv
// rtl/mib_pattern_pkg.sv - shared types and default pattern table for the pattern checker
`timescale 1ns/1ps
package mib_pattern_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 13;
    localparam int DEFAULT_NUM_PATTERNS = 7;

    // Index 0 sits in the least significant DATA_WIDTH bits.
    localparam logic [DEFAULT_NUM_PATTERNS*DEFAULT_DATA_WIDTH-1:0] DEFAULT_PATTERNS = {
        13'h00F5, 13'h1FFF, 13'h0000, 13'h10F0, 13'h0F0F, 13'h0555, 13'h0AAA
    };

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HUNT  = 3'd1,
        ST_TRACK = 3'd2,
        ST_PASS  = 3'd3,
        ST_ERROR = 3'd4
    } mib_state_t;

endpackage

// File: rtl/mib_seq_index.sv
// rtl/mib_seq_index.sv - expected-pattern index with wrap detection and completed-loop count
`timescale 1ns/1ps
module mib_seq_index #(
    parameter int NUM_PATTERNS = 7,
    parameter int PASS_LOOPS   = 16,
    parameter int IDX_W        = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    parameter int LOOP_W       = $clog2(PASS_LOOPS + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clear,
    input  logic              i_lock,
    input  logic              i_advance,
    output logic [IDX_W-1:0]  o_idx,
    output logic [LOOP_W-1:0] o_loop_count,
    output logic              o_loop_done
);

    logic wrap;

    assign wrap        = (o_idx == IDX_W'(NUM_PATTERNS - 1));
    assign o_loop_done = i_advance && wrap && (o_loop_count == LOOP_W'(PASS_LOOPS - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_idx        <= '0;
            o_loop_count <= '0;
        end else if (i_clear) begin
            o_idx        <= '0;
            o_loop_count <= '0;
        end else if (i_lock) begin
            // Hunt already consumed pattern 0, so tracking expects pattern 1 next.
            o_idx        <= IDX_W'(1);
            o_loop_count <= '0;
        end else if (i_advance) begin
            if (wrap) begin
                o_idx <= '0;
                if (o_loop_count != LOOP_W'(PASS_LOOPS))
                    o_loop_count <= o_loop_count + LOOP_W'(1);
            end else begin
                o_idx <= o_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/mib_pattern_checker.sv
// rtl/mib_pattern_checker.sv - locks onto a repeating bus pattern and flags pass or error
`timescale 1ns/1ps
module mib_pattern_checker
    import mib_pattern_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int NUM_PATTERNS = DEFAULT_NUM_PATTERNS,
    parameter logic [NUM_PATTERNS*DATA_WIDTH-1:0] PATTERNS = DEFAULT_PATTERNS,
    parameter int PASS_LOOPS   = 16,
    parameter int ERR_LIMIT    = 4
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic                             i_start,
    input  logic [DATA_WIDTH-1:0]            i_data,
    input  logic                             i_data_valid,
    output logic                             o_locked,
    output logic                             o_pass,
    output logic                             o_error,
    output logic [$clog2(ERR_LIMIT+1)-1:0]   o_err_count,
    output logic [$clog2(PASS_LOOPS+1)-1:0]  o_loop_count
);

    localparam int IDX_W  = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);
    localparam int LOOP_W = $clog2(PASS_LOOPS + 1);

    mib_state_t           state, state_nxt;
    logic                 start_low_q;
    logic                 start_rise;
    logic [IDX_W-1:0]     idx;
    logic [DATA_WIDTH-1:0] expected;
    logic                 match_first;
    logic                 match_idx;
    logic                 seq_clear, seq_lock, seq_advance, err_inc;
    logic                 loop_done;

    // start_low_q resets to 0, so a start held high through reset release
    // must drop and rise again before it counts as an edge.
    assign start_rise = i_start && start_low_q;

    always_comb begin
        expected = PATTERNS[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign match_first = (i_data == PATTERNS[DATA_WIDTH-1:0]);
    assign match_idx   = (i_data == expected);

    mib_seq_index #(
        .NUM_PATTERNS (NUM_PATTERNS),
        .PASS_LOOPS   (PASS_LOOPS),
        .IDX_W        (IDX_W),
        .LOOP_W       (LOOP_W)
    ) u_seq_index (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clear      (seq_clear),
        .i_lock       (seq_lock),
        .i_advance    (seq_advance),
        .o_idx        (idx),
        .o_loop_count (o_loop_count),
        .o_loop_done  (loop_done)
    );

    always_comb begin
        state_nxt   = state;
        seq_clear   = 1'b0;
        seq_lock    = 1'b0;
        seq_advance = 1'b0;
        err_inc     = 1'b0;
        if (start_rise) begin
            state_nxt = ST_HUNT;
            seq_clear = 1'b1;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (i_data_valid && match_first) begin
                        seq_lock  = 1'b1;
                        state_nxt = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (i_data_valid) begin
                        if (match_idx) begin
                            seq_advance = 1'b1;
                            if (loop_done)
                                state_nxt = ST_PASS;
                        end else begin
                            seq_clear = 1'b1;
                            err_inc   = 1'b1;
                            state_nxt = (o_err_count == ERR_W'(ERR_LIMIT - 1)) ? ST_ERROR : ST_HUNT;
                        end
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            start_low_q <= 1'b0;
            o_locked    <= 1'b0;
            o_pass      <= 1'b0;
            o_error     <= 1'b0;
            o_err_count <= '0;
        end else begin
            state       <= state_nxt;
            start_low_q <= !i_start;
            o_locked    <= (state_nxt == ST_TRACK);
            o_pass      <= (state_nxt == ST_PASS);
            o_error     <= (state_nxt == ST_ERROR);
            if (start_rise)
                o_err_count <= '0;
            else if (err_inc)
                o_err_count <= o_err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_mib_pattern_checker.sv
// tb/tb_mib_pattern_checker.sv - directed self-checking bench for mib_pattern_checker
`timescale 1ns/1ps
module tb_mib_pattern_checker;
    import mib_pattern_pkg::*;

    logic        clk_25;
    logic        reset_n;
    logic        start;
    logic [12:0] data;
    logic        data_valid;
    logic        locked;
    logic        pass;
    logic        error;
    logic [2:0]  err_count;
    logic [4:0]  loop_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [12:0] pat [7] = '{13'h0AAA, 13'h0555, 13'h0F0F, 13'h10F0, 13'h0000, 13'h1FFF, 13'h00F5};

    mib_pattern_checker dut (
        .i_clk        (clk_25),
        .i_reset_n    (reset_n),
        .i_start      (start),
        .i_data       (data),
        .i_data_valid (data_valid),
        .o_locked     (locked),
        .o_pass       (pass),
        .o_error      (error),
        .o_err_count  (err_count),
        .o_loop_count (loop_count)
    );

    initial clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input logic [12:0] w, input logic v);
        @(negedge clk_25);
        data       = w;
        data_valid = v;
        @(posedge clk_25);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic arm();
        @(negedge clk_25);
        start      = 1'b1;
        data_valid = 1'b0;
        @(posedge clk_25);
        #1;
        @(negedge clk_25);
        start = 1'b0;
    endtask

    task automatic send_loops(input int n);
        for (int l = 0; l < n; l++)
            for (int k = 0; k < 7; k++)
                step(pat[k], 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        data       = '0;
        data_valid = 1'b0;
        repeat (3) @(posedge clk_25);
        #1;
        check("rst_locked", locked, 0);
        check("rst_pass", pass, 0);
        check("rst_error", error, 0);
        check("rst_err_count", err_count, 0);
        check("rst_loop_count", loop_count, 0);
        check("rst_state", int'(dut.state), int'(ST_IDLE));
        @(negedge clk_25);
        reset_n = 1'b1;
        step(13'h0AAA, 1'b1);
        check("idle_ignores_data", locked, 0);

        // Clean run of 16 loops
        arm();
        check("t1_armed_state", int'(dut.state), int'(ST_HUNT));
        step(13'h0AAA, 1'b1);
        check("t1_lock_first", locked, 1);
        for (int k = 1; k < 7; k++) step(pat[k], 1'b1);
        check("t1_loop1", loop_count, 1);
        send_loops(14);
        for (int k = 0; k < 6; k++) step(pat[k], 1'b1);
        check("t1_pass_before_last", pass, 0);
        check("t1_loops_before_last", loop_count, 15);
        step(13'h00F5, 1'b1);
        check("t1_pass", pass, 1);
        check("t1_locked_off", locked, 0);
        check("t1_err_count", err_count, 0);
        check("t1_loop_count", loop_count, 16);
        step(13'h0123, 1'b1);
        check("t1_pass_sticky", pass, 1);

        // Garbage before the sequence
        arm();
        step(13'h0123, 1'b1);
        step(13'h1555, 1'b1);
        step(13'h0AAB, 1'b1);
        check("t2_still_hunt", int'(dut.state), int'(ST_HUNT));
        check("t2_no_err", err_count, 0);
        check("t2_not_locked", locked, 0);
        step(13'h0AAA, 1'b1);
        check("t2_lock", locked, 1);
        for (int k = 1; k < 7; k++) step(pat[k], 1'b1);
        check("t2_loop1", loop_count, 1);

        // Single corrupt word in loop 5
        arm();
        send_loops(4);
        check("t3_loops4", loop_count, 4);
        step(13'h0AAA, 1'b1);
        step(13'h0556, 1'b1);
        check("t3_err1", err_count, 1);
        check("t3_loop_cleared", loop_count, 0);
        check("t3_state_hunt", int'(dut.state), int'(ST_HUNT));
        check("t3_unlocked", locked, 0);
        for (int k = 2; k < 7; k++) step(pat[k], 1'b1);
        check("t3_hunt_no_err", err_count, 1);
        send_loops(15);
        for (int k = 0; k < 6; k++) step(pat[k], 1'b1);
        check("t3_no_pass_yet", pass, 0);
        step(13'h00F5, 1'b1);
        check("t3_pass", pass, 1);
        check("t3_err_kept", err_count, 1);

        // Four mismatches reach terminal error
        arm();
        for (int i = 0; i < 4; i++) begin
            step(13'h0AAA, 1'b1);
            step(13'h0000, 1'b1);
            check("t4_err_count", err_count, i + 1);
            if (i == 2) check("t4_no_error_at3", error, 0);
        end
        check("t4_error", error, 1);
        check("t4_state_error", int'(dut.state), int'(ST_ERROR));
        check("t4_unlocked", locked, 0);
        send_loops(16);
        check("t4_no_pass", pass, 0);
        check("t4_error_sticky", error, 1);
        check("t4_err_saturated", err_count, 4);

        // Random valid gaps during clean data
        arm();
        check("t5_cleared_err", err_count, 0);
        check("t5_cleared_error", error, 0);
        for (int l = 0; l < 16; l++) begin
            for (int k = 0; k < 7; k++) begin
                logic sent;
                sent = 1'b0;
                while (!sent) begin
                    logic v;
                    v = 1'($urandom_range(0, 1));
                    step(v ? pat[k] : 13'($urandom), v);
                    sent = v;
                end
            end
            if (l == 7) check("t5_loops8", loop_count, 8);
        end
        check("t5_pass", pass, 1);
        check("t5_err_count", err_count, 0);

        // Asynchronous reset mid-track; start held high through release
        arm();
        send_loops(1);
        step(13'h0AAA, 1'b1);
        check("t6_locked_before", locked, 1);
        check("t6_loop_before", loop_count, 1);
        @(negedge clk_25);
        reset_n = 1'b0;
        start   = 1'b1;
        #5;
        check("t6_async_locked", locked, 0);
        check("t6_async_loop", loop_count, 0);
        check("t6_async_state", int'(dut.state), int'(ST_IDLE));
        repeat (2) @(negedge clk_25);
        reset_n = 1'b1;
        step(13'h0AAA, 1'b1);
        check("t6_held_start_no_edge", int'(dut.state), int'(ST_IDLE));
        check("t6_no_relock", locked, 0);
        @(negedge clk_25);
        start = 1'b0;
        arm();
        step(13'h0AAA, 1'b1);
        check("t6_relock", locked, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mib_pattern_checker.md
MIB_PATTERN_CHECKER -- requirements
Module: mib_pattern_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 13, width of checked bus.
REQ-002 SHALL have parameter NUM_PATTERNS, default 7, length of the repeating sequence (range 2..16).
REQ-003 SHALL have parameter PATTERNS, default {0AAA,0555,0F0F,10F0,0000,1FFF,00F5} hex, the expected sequence with index 0 first.
REQ-004 SHALL have parameter PASS_LOOPS, default 16, number of complete sequences required to declare pass.
REQ-005 SHALL have parameter ERR_LIMIT, default 4, number of mismatches tolerated before terminal error.
REQ-006 SHALL have port i_clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-007 SHALL have port i_reset_n, input, 1, reset that is asynchronous and active-low.
REQ-008 SHALL have port i_start, input, 1, level; a rising edge (re)arms checking.
REQ-009 SHALL have port i_data, input, DATA_WIDTH, the sampled bus word.
REQ-010 SHALL have port i_data_valid, input, 1, qualifies i_data; the checker ignores a cycle when low.
REQ-011 SHALL have port o_locked, output, 1, high while in TRACK.
REQ-012 SHALL have port o_pass, output, 1, sticky pass flag.
REQ-013 SHALL have port o_error, output, 1, sticky terminal error flag (drives board LED).
REQ-014 SHALL have port o_err_count, output, clog2(ERR_LIMIT+1), number of mismatches since arm.
REQ-015 SHALL have port o_loop_count, output, clog2(PASS_LOOPS+1), number of completed sequences since the last (re)lock.

Function
REQ-016 SHALL implement FSM states IDLE, HUNT, TRACK, PASS, ERROR.
REQ-017 SHALL move IDLE->HUNT on an i_start rising edge, clearing the counts, flags and index in that cycle.
REQ-018 SHALL, in HUNT, on a valid word equal to PATTERNS[0], go to TRACK with expected index 1; a non-matching word leaves it in HUNT and does not count as an error.
REQ-019 SHALL, in TRACK, on a valid word equal to PATTERNS[idx], advance idx, wrapping from NUM_PATTERNS-1 to 0.
REQ-020 SHALL increment o_loop_count when a match occurs at idx NUM_PATTERNS-1 (wrap).
REQ-021 SHALL enter PASS and set o_pass in the cycle after the wrap that brings o_loop_count to PASS_LOOPS.
REQ-022 SHALL, in TRACK, on a valid mismatch, increment o_err_count, clear o_loop_count and return to HUNT (resync).
REQ-023 SHALL enter ERROR and set o_error when a mismatch brings o_err_count to ERR_LIMIT; the count saturates there.
REQ-024 SHALL treat PASS and ERROR as terminal: only a new i_start rising edge (->HUNT) or reset leaves them.
REQ-025 SHALL, when i_start rises while in HUNT or TRACK, restart (counts cleared, ->HUNT); an i_start edge takes priority over data in the same cycle.
REQ-026 SHALL NOT advance any state or counter when i_data_valid is low, including during a partial sequence.
REQ-027 SHALL compare i_data against the pattern combinationally, with registered outputs only: one cycle of latency from a valid word to the output update.

Reset
REQ-028 SHALL, while i_reset_n is low, force state IDLE, idx 0, o_locked 0, o_pass 0, o_error 0, o_err_count 0, o_loop_count 0, and the i_start edge detector register 0.
REQ-029 SHALL assert reset asynchronously; release is synchronous to i_clk, and the integrating top level supplies the synchroniser.
REQ-030 SHALL NOT detect an i_start held high across reset release as an edge until it deasserts and reasserts.

Structure
REQ-031 SHALL place the state enum type, the default pattern table and the default values of DATA_WIDTH/NUM_PATTERNS in package mib_pattern_pkg.
REQ-032 SHALL place the expected-index counter with its wrap/loop-count logic in one sub-module, mib_seq_index.

Verification
REQ-033 SHALL verify: start, then 16 clean loops of the default sequence -> o_locked 1 after the first 0AAA, o_pass 1 one cycle after the 16th 00F5, o_err_count 0.
REQ-034 SHALL verify: 3 garbage words, then the sequence -> state stays HUNT, o_err_count 0, and lock occurs on the first 0AAA.
REQ-035 SHALL verify: a single corrupt word (0556 instead of 0555) in loop 5 -> o_err_count 1, o_loop_count 0, return to HUNT, then pass after 16 further loops.
REQ-036 SHALL verify: 4 injected mismatches -> o_error 1, state ERROR, and no pass even after further clean data.
REQ-037 SHALL verify: i_data_valid toggled 50% random during clean data -> identical result to REQ-033 (o_pass 1, o_err_count 0).
REQ-038 SHALL verify: i_reset_n pulsed low mid-TRACK -> all outputs 0 immediately (asynchronously), state IDLE, and relock only after a new i_start edge.
